// File: rtl/io_map_pkg.sv
// Register offsets and bus helpers for the LED/switch IO page.
package io_map_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0040_0000;

    localparam logic [11:0] LED_EN_OFS    = 12'h000;
    localparam logic [11:0] SW_IN_OFS     = 12'h004;
    localparam logic [11:0] SW_EDGE_OFS   = 12'h008;
    localparam logic [11:0] DUTY_BASE_OFS = 12'h100;

    // Expands the 4-bit byte-lane mask into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch: 2-flop synchroniser, stability counter, debounced level and rise pulse.
// Level follows a sustained input change 2 + DEBOUNCE_CYCLES cycles later; o_rise is a 1-cycle pulse.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic i_sw,
    output logic o_level,
    output logic o_rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_flip;

    // The edge that would take the counter to DEBOUNCE_CYCLES flips the level instead.
    assign w_diff = (r_s2 != r_deb);
    assign w_flip = w_diff && (r_cnt == LAST);

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_sw;
            r_s2 <= r_s1;
            if (w_diff && !w_flip)
                r_cnt <= r_cnt + CW'(1);
            else
                r_cnt <= '0;
            if (w_flip)
                r_deb <= r_s2;
        end
    end

    assign o_level = r_deb;
    assign o_rise  = w_flip & r_s2;

endmodule

// File: rtl/led_io_ctrl.sv
// Memory-mapped LED PWM / debounced switch peripheral; registered read data one cycle after strobe.
// Writes commit at the clock edge with byte-lane masking; read data is zero when not selected.
module led_io_ctrl
    import io_map_pkg::*;
#(
    parameter int          NUM_LEDS        = 8,
    parameter int          NUM_SW          = 3,
    parameter int          PWM_BITS        = 8,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR       = DEF_BASE_ADDR
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [31:0]         memory_address,
    input  logic                memory_read_strobe,
    input  logic [31:0]         memory_write_data,
    input  logic [3:0]          memory_write_mask,
    output logic [31:0]         memory_read_data,
    input  logic [NUM_SW-1:0]   SW,
    output logic [NUM_LEDS-1:0] LED
);
    localparam logic [9:0] W_LED_EN  = LED_EN_OFS[11:2];
    localparam logic [9:0] W_SW_IN   = SW_IN_OFS[11:2];
    localparam logic [9:0] W_SW_EDGE = SW_EDGE_OFS[11:2];
    localparam logic [9:0] W_DUTY    = DUTY_BASE_OFS[11:2];

    logic                w_sel;
    logic [9:0]          w_wofs;
    logic                w_wr;
    logic [31:0]         w_bmask;
    logic [31:0]         w_rd_val;
    logic [NUM_SW-1:0]   w_sw_lvl;
    logic [NUM_SW-1:0]   w_sw_rise;
    logic [NUM_SW-1:0]   w_clr;
    logic [NUM_LEDS-1:0] w_on;
    logic                w_unused;

    logic [NUM_LEDS-1:0] r_led_en;
    logic [NUM_SW-1:0]   r_sw_edge;
    logic [PWM_BITS-1:0] r_duty [NUM_LEDS];
    logic [PWM_BITS-1:0] r_pwm_cnt;

    assign w_sel    = (memory_address[31:12] == BASE_ADDR[31:12]);
    assign w_wofs   = memory_address[11:2];
    assign w_wr     = w_sel && (|memory_write_mask);
    assign w_bmask  = lane_mask(memory_write_mask);
    assign w_unused = ^{memory_address[1:0], memory_write_data, w_bmask};

    genvar j;
    generate
        for (j = 0; j < NUM_SW; j++) begin : g_sw
            sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .CLK     (CLK),
                .reset   (reset),
                .i_sw    (SW[j]),
                .o_level (w_sw_lvl[j]),
                .o_rise  (w_sw_rise[j])
            );
        end
    endgenerate

    always_comb begin
        w_rd_val = '0;
        case (w_wofs)
            W_LED_EN:  w_rd_val = 32'(r_led_en);
            W_SW_IN:   w_rd_val = 32'(w_sw_lvl);
            W_SW_EDGE: w_rd_val = 32'(r_sw_edge);
            default:   w_rd_val = '0;
        endcase
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (w_wofs == W_DUTY + 10'(i))
                w_rd_val = 32'(r_duty[i]);
        end
    end

    assign w_clr = (w_wr && (w_wofs == W_SW_EDGE)) ?
                   (memory_write_data[NUM_SW-1:0] & w_bmask[NUM_SW-1:0]) : '0;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_led_en  <= '0;
            r_sw_edge <= '0;
            for (int i = 0; i < NUM_LEDS; i++)
                r_duty[i] <= '1;
        end else begin
            if (w_wr && (w_wofs == W_LED_EN))
                r_led_en <= (r_led_en & ~w_bmask[NUM_LEDS-1:0]) |
                            (memory_write_data[NUM_LEDS-1:0] & w_bmask[NUM_LEDS-1:0]);
            // A rise landing on the same edge as its W1C clear must survive.
            r_sw_edge <= (r_sw_edge & ~w_clr) | w_sw_rise;
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (w_wr && (w_wofs == W_DUTY + 10'(i)))
                    r_duty[i] <= (r_duty[i] & ~w_bmask[PWM_BITS-1:0]) |
                                 (memory_write_data[PWM_BITS-1:0] & w_bmask[PWM_BITS-1:0]);
            end
        end
    end

    always_comb begin
        w_on = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            w_on[i] = r_led_en[i] & ((r_pwm_cnt < r_duty[i]) | (&r_duty[i]));
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_pwm_cnt        <= '0;
            LED              <= '0;
            memory_read_data <= '0;
        end else begin
            r_pwm_cnt        <= r_pwm_cnt + PWM_BITS'(1);
            LED              <= w_on;
            memory_read_data <= (w_sel && memory_read_strobe) ? w_rd_val : '0;
        end
    end

endmodule

// File: doc/led_io_ctrl.md
Name: led_io_ctrl

Overview:
Memory-mapped LED/switch peripheral on the CPU data bus; replaces the hard-wired x1-to-LED hookup in soc.
- Provides NUM_LEDS individually enabled LED channels, each with its own PWM brightness.
- Provides NUM_SW debounced switch inputs with sticky rising-edge flags.
- Uses the same address/read-strobe bus as RAM, extended with write data and byte mask.
- Read data is zero when not selected, so soc ORs it with RAM read data.

Parameters:
NUM_LEDS, 8, LED channel count (1..16)
NUM_SW, 3, switch input count (1..16)
PWM_BITS, 8, PWM counter and duty width
DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a switch change (>=1)
BASE_ADDR, 32'h0040_0000, IO page base; only bits [31:12] are compared

Ports:
CLK  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
memory_address  in  32  byte address from CPU
memory_read_strobe  in  1  read request
memory_write_data  in  32  write data
memory_write_mask  in  4  byte-lane write enables; nonzero means write
memory_read_data  out  32  registered read data
SW  in  NUM_SW  raw asynchronous switches
LED  out  NUM_LEDS  registered LED drive

Behaviour:
- Select: sel = (memory_address[31:12] == BASE_ADDR[31:12]); word offset = memory_address[11:2].
- Register map, by byte offset:
  - 0x000 LED_EN: RW, [NUM_LEDS-1:0].
  - 0x004 SW_IN: RO, debounced switch levels.
  - 0x008 SW_EDGE: sticky rising-edge flags; write 1 to clear.
  - 0x100+4*i DUTY[i]: RW, [PWM_BITS-1:0], for i < NUM_LEDS.
  - Unmapped offsets read 0; writes to them are ignored. Unused upper bits read 0.
- Reads:
  - sel & memory_read_strobe in cycle N -> memory_read_data valid in cycle N+1.
  - Otherwise memory_read_data = 0 in N+1.
  - Reads have no side effects, including SW_EDGE.
- Writes:
  - sel & |memory_write_mask commits at the clock edge.
  - Byte lanes with mask bit 0 keep their old value.
  - Read and write in the same cycle: read returns the pre-write value.
- PWM:
  - Free-running pwm_cnt of PWM_BITS wraps from max to 0.
  - on_i = LED_EN[i] & ((pwm_cnt < DUTY[i]) | (DUTY[i] == all-ones)).
  - LED[i] <= on_i, so LED lags pwm_cnt by 1 cycle.
  - DUTY = 0 means always off; all-ones means always on.
  - DUTY writes take effect on the next cycle; no period-boundary shadowing.
- Switch path:
  - 2-flop synchroniser per switch.
  - Per-switch counter of width $clog2(DEBOUNCE_CYCLES+1) increments while the synced value != debounced value, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced value flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
  - Latency from SW change to SW_IN is 2 + DEBOUNCE_CYCLES cycles.
- SW_EDGE[j] sets on a debounced 0->1 transition. A W1C write clears it. If set and clear happen in the same cycle, set wins.
- Reset (reset == 0 at a rising edge) overrides any concurrent bus access:
  - LED, memory_read_data, LED_EN, SW_IN, SW_EDGE, synchronisers, counters and pwm_cnt go to 0.
  - DUTY[i] goes to all-ones.
  - Reset mid-read: no data is returned in the following cycle.

Decomposition:
- Package io_map_pkg holds the offset constants LED_EN_OFS, SW_IN_OFS, SW_EDGE_OFS, DUTY_BASE_OFS and the default BASE_ADDR.
- Sub-module sw_debounce (synchroniser + counter + debounced flop + rise pulse, parameter DEBOUNCE_CYCLES) is instantiated NUM_SW times in a generate loop.
- PWM compare and bus decode stay in the top level.

Test Plan:
1. Hold reset low 3 cycles, then read LED_EN, SW_IN, SW_EDGE, DUTY[0] -> 0, 0, 0, 0xFF; LED = 0 throughout.
2. Write LED_EN = 0x05 (mask 4'b0001) with default duty -> LED = 8'h05 from the 2nd cycle after the write. Then write DUTY[2] = 0x40 -> LED[2] high exactly 64 of each 256 cycles. Then write DUTY[0] = 0 -> LED[0] stays 0.
3. Raise SW[1] for 3 cycles then drop it -> SW_IN stays 0 and SW_EDGE stays 0. Raise SW[1] and hold -> SW_IN[1] = 1 exactly 6 cycles after the change; SW_EDGE = 0x2.
4. With SW_EDGE[1] = 1, write 0x2 to SW_EDGE -> reads 0. Repeat with a new debounced rise landing in the same cycle as the W1C write -> reads 0x2.
5. Read offset 0x0C -> 0. Read while memory_address = 0x0000_0004 (RAM space) -> memory_read_data = 0. Write 0xDEADBEEF with mask 4'b0010 to DUTY[1] (was 0xFF) -> DUTY[1] reads 0xFF, since byte 0 is unchanged and only the low PWM_BITS are stored.
6. Assert reset in the cycle after a read strobe -> memory_read_data = 0 next cycle; all state at reset values; PWM restarts from pwm_cnt = 0.
